// File: rtl/dmem_responder_if.sv
// Request/response bundle between the CPU memory stage and the data-memory responder.
// The CPU side is the master. The responder side is the slave.
interface dmem_responder_if;
  logic        req_en;
  logic [3:0]  req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;

  modport master (
    output req_en, req_wen, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_en, req_wen, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word reads and byte-enabled writes against an internal array,
// with a ready/valid handshake and a fixed number of programmable wait states.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input logic              clk,
  input logic              rst,
  dmem_responder_if.slave  mem_io
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WaitInit = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [3:0]              wen_q;
  logic [31:0]             wdata_q;
  logic [31:0]             rdata_q;
  logic                    valid_q;
  logic [31:0]             mem_q [Depth];

  // Byte-offset and aliased upper address bits are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^{mem_io.req_addr[31:ADDR_WIDTH+2], mem_io.req_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mem_io.req_en) begin
            idx_q   <= mem_io.req_addr[ADDR_WIDTH+1:2];
            wen_q   <= mem_io.req_wen;
            wdata_q <= mem_io.req_wdata;
            if (WAIT_CYCLES > 0) begin
              state_q <= StWait;
              cnt_q   <= WaitInit;
            end else begin
              state_q <= StAccess;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q <= StAccess;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StAccess: begin
          rdata_q <= (wen_q == 4'b0000) ? mem_q[idx_q] : 32'h0;
          valid_q <= 1'b1;
          state_q <= StResp;
        end
        StResp: begin
          valid_q <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Array is never reset; a reset before the commit edge drops the pending write.
  always_ff @(posedge clk) begin
    if (!rst && state_q == StAccess) begin
      for (int i = 0; i < 4; i++) begin
        if (wen_q[i]) begin
          mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign mem_io.req_ready  = (state_q == StIdle) && !rst;
  assign mem_io.resp_valid = valid_q;
  assign mem_io.resp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded random bench: two responders (0 and 3 wait states) checked against a
// word-array reference model for data and response latency.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst3 = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if i0 ();
  dmem_responder_if i3 ();

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u0 (.clk(clk), .rst(rst0), .mem_io(i0));
  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) u3 (.clk(clk), .rst(rst3), .mem_io(i3));

  typedef struct {
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t        exp0[$];
  exp_t        exp3[$];
  logic [31:0] m0 [1024];
  logic [31:0] m3 [1024];
  int          issued0 = 0, issued3 = 0, seen0 = 0, seen3 = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? i0.req_ready : i3.req_ready;
  endfunction

  task automatic drive(input int d, input logic en, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (d == 0) begin
      i0.req_en = en; i0.req_wen = wen; i0.req_addr = addr; i0.req_wdata = wdata;
    end else begin
      i3.req_en = en; i3.req_wen = wen; i3.req_addr = addr; i3.req_wdata = wdata;
    end
  endtask

  // Reference: word index is the byte address divided by four, modulo the depth.
  task automatic model(input int d, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rd);
    int unsigned idx = (addr / 4) % 1024;
    logic [31:0] w = (d == 0) ? m0[idx] : m3[idx];
    rd = (wen == 4'b0000) ? w : 32'h0;
    for (int b = 0; b < 4; b++)
      if (wen[b]) w[8*b +: 8] = wdata[8*b +: 8];
    if (d == 0) m0[idx] = w; else m3[idx] = w;
  endtask

  // Waits for ready, presents one request for one edge and records the expected response.
  // With poke set, a request is also pulsed during the busy cycle that must be dropped.
  task automatic issue(input int d, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit poke = 0);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (!rdy(d) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL ready_timeout dut%0d: req_ready stayed 0, expected 1", d);
      return;
    end
    drive(d, 1'b1, wen, addr, wdata);
    model(d, wen, addr, wdata, e.rdata);
    e.cyc = cyc + 2 + ((d == 0) ? 0 : 3);
    if (d == 0) begin exp0.push_back(e); issued0++; end
    else begin exp3.push_back(e); issued3++; end
    @(negedge clk);
    if (poke) drive(d, 1'b1, 4'hF, 32'h0, 32'h0BAD_0BAD);
    else drive(d, 1'b0, 4'h0, 32'h0, 32'h0);
    if (poke) begin
      @(negedge clk);
      drive(d, 1'b0, 4'h0, 32'h0, 32'h0);
    end
  endtask

  task automatic mon(input int d, input logic [31:0] rdata);
    exp_t e;
    if (d == 0) seen0++; else seen3++;
    if ((d == 0 && exp0.size() == 0) || (d == 3 && exp3.size() == 0)) begin
      checks++; errors++;
      $display("FAIL unexpected_resp dut%0d: resp_valid=1 at cycle %0d, expected 0", d, cyc);
      return;
    end
    e = (d == 0) ? exp0.pop_front() : exp3.pop_front();
    check32($sformatf("rdata dut%0d", d), rdata, e.rdata);
    check32($sformatf("latency dut%0d", d), 32'(cyc), 32'(e.cyc));
  endtask

  always @(negedge clk) begin
    if (i0.resp_valid === 1'b1) mon(0, i0.resp_rdata);
    if (i3.resp_valid === 1'b1) mon(3, i3.resp_rdata);
  end

  task automatic check_after_reset(input int d);
    check32($sformatf("ready_after_rst dut%0d", d), 32'(rdy(d)), 32'd1);
    check32($sformatf("valid_after_rst dut%0d", d),
            32'((d == 0) ? i0.resp_valid : i3.resp_valid), 32'd0);
    check32($sformatf("rdata_after_rst dut%0d", d),
            (d == 0) ? i0.resp_rdata : i3.resp_rdata, 32'h0);
  endtask

  task automatic random_ops(input int d, input int count);
    for (int k = 0; k < count; k++) begin
      logic [3:0]  wen  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      logic [31:0] addr = {20'($urandom), 4'h0, 6'($urandom_range(0, 63)), 2'($urandom)};
      issue(d, wen, addr, $urandom);
    end
  endtask

  initial begin
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(3, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    check32("ready_in_rst dut0", 32'(i0.req_ready), 32'd0);
    check32("ready_in_rst dut3", 32'(i3.req_ready), 32'd0);
    @(negedge clk);
    rst0 = 1'b0;
    rst3 = 1'b0;
    #1;
    check_after_reset(0);
    check_after_reset(3);

    // Seed words 0..63 so the model never has to predict unknown contents.
    for (int w = 0; w < 64; w++) begin
      issue(0, 4'hF, 32'(w * 4), $urandom);
      issue(3, 4'hF, 32'(w * 4), $urandom);
    end

    // Zero wait states: full store, read back, byte merge, aliasing.
    issue(0, 4'hF, 32'h10, 32'hDEAD_BEEF);
    issue(0, 4'h0, 32'h10, 32'h0);
    issue(0, 4'b0101, 32'h10, 32'h1122_3344);
    issue(0, 4'h0, 32'h10, 32'h0);
    issue(0, 4'hF, 32'h0000_1003, 32'hA5A5_A5A5);
    issue(0, 4'h0, 32'h0000_0000, 32'h0);
    random_ops(0, 60);

    // Three wait states: ready stays low through the whole transaction.
    issue(3, 4'hF, 32'h0, 32'h5A5A_0F0F);
    @(negedge clk);
    drive(3, 1'b1, 4'h0, 32'h4, 32'h0);
    @(negedge clk);
    drive(3, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) check32($sformatf("busy_ready dut3 k%0d", k), 32'(i3.req_ready), 32'd0);
    issue(3, 4'h0, 32'h0, 32'h0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      check32($sformatf("wait_ready dut3 k%0d", k), 32'(i3.req_ready), 32'd0);
      @(negedge clk);
    end
    check32("resp_ready dut3", 32'(i3.req_ready), 32'd0);
    @(negedge clk);
    check32("idle_ready dut3", 32'(i3.req_ready), 32'd1);
    issue(3, 4'h0, 32'h0, 32'h0);

    // Reset while the write waits: no response and the word keeps its old value.
    issue(3, 4'hF, 32'h20, 32'h0);
    repeat (8) @(negedge clk);
    drive(3, 1'b1, 4'hF, 32'h20, 32'h1234_5678);
    @(negedge clk);
    drive(3, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst3 = 1'b0;
    #1;
    check_after_reset(3);
    issue(3, 4'h0, 32'h20, 32'h0);
    issue(3, 4'hF, 32'h0000_1003, 32'hA5A5_A5A5);
    issue(3, 4'h0, 32'h0, 32'h0);
    random_ops(3, 40);

    repeat (20) @(negedge clk);
    check32("drain dut0", 32'(exp0.size()), 32'd0);
    check32("drain dut3", 32'(exp3.size()), 32'd0);
    check32("resp_count dut0", 32'(seen0), 32'(issued0));
    check32("resp_count dut3", 32'(seen3), 32'(issued3));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1);
  end

endmodule
